// File: rtl/mem_stage_ls_if.sv
// Data-memory bus between the MEM stage (master) and the data memory (slave).
//   dm_req   : access request, held until dm_ack or abandonment
//   dm_we    : 1 = store, 0 = load
//   dm_be    : byte enables, big-endian lanes (bit 3 = data[31:24] = offset 0)
//   dm_addr  : word-aligned byte address
//   dm_wdata : store data already replicated into the lanes
//   dm_rdata : load data, valid in the dm_ack cycle
//   dm_ack   : access completes this cycle
interface mem_stage_ls_if #(
  parameter int ADDR_W = 32
);
  logic              dm_req;
  logic              dm_we;
  logic [3:0]        dm_be;
  logic [ADDR_W-1:0] dm_addr;
  logic [31:0]       dm_wdata;
  logic [31:0]       dm_rdata;
  logic              dm_ack;

  modport master (output dm_req, dm_we, dm_be, dm_addr, dm_wdata, input dm_rdata, dm_ack);
  modport slave  (input dm_req, dm_we, dm_be, dm_addr, dm_wdata, output dm_rdata, dm_ack);
endinterface

// File: rtl/mem_stage_ls.sv
// MEM stage plus MEM/WB register of the five-stage MIPS pipeline.
// Passes register-file and HI/LO write-back info from EX to WB and executes
// byte/half/word loads and stores over a req/ack data-memory bus.
//   clk, rst                : clock, synchronous active-high reset
//   ex_valid_i ... mem_*_i  : EX result, write-back controls and memory op
//   dm                      : data-memory bus (master side)
//   stall_req_o             : hold EX and earlier stages while an access waits
//   wb_valid_o ... whilo_o  : registered write-back outputs
//   adel_o/ades_o/berr_o    : misaligned load/store, bus time-out pulses
module mem_stage_ls #(
  parameter int ADDR_W  = 32,
  parameter int RADDR_W = 5,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ex_valid_i,
  input  logic [RADDR_W-1:0] wd_i,
  input  logic               wreg_i,
  input  logic [31:0]        wdata_i,
  input  logic [31:0]        hi_i,
  input  logic [31:0]        lo_i,
  input  logic               whilo_i,
  input  logic [3:0]         mem_op_i,
  input  logic [ADDR_W-1:0]  mem_addr_i,
  input  logic [31:0]        mem_sdata_i,
  mem_stage_ls_if.master     dm,
  output logic               stall_req_o,
  output logic               wb_valid_o,
  output logic [RADDR_W-1:0] wd_o,
  output logic               wreg_o,
  output logic [31:0]        wdata_o,
  output logic [31:0]        hi_o,
  output logic [31:0]        lo_o,
  output logic               whilo_o,
  output logic               adel_o,
  output logic               ades_o,
  output logic               berr_o
);
  localparam logic [3:0] OP_LB = 4'd1, OP_LBU = 4'd2, OP_LH = 4'd3, OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW = 4'd5, OP_SB  = 4'd6, OP_SH = 4'd7, OP_SW  = 4'd8;
  localparam logic [1:0] SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2;
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_e;

  // Big-endian lane select plus sign/zero extension of load data.
  function automatic logic [31:0] load_extract(input logic [31:0] rdata, input logic [1:0] off,
                                               input logic [1:0] sz, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = rdata[31:24];
      2'd1:    b = rdata[23:16];
      2'd2:    b = rdata[15:8];
      default: b = rdata[7:0];
    endcase
    h = off[1] ? rdata[15:0] : rdata[31:16];
    case (sz)
      SZ_B:    r = {{24{sgn & b[7]}}, b};
      SZ_H:    r = {{16{sgn & h[15]}}, h};
      default: r = rdata;
    endcase
    return r;
  endfunction

  // Byte enables for a store of the given size at the given offset.
  function automatic logic [3:0] store_be(input logic [1:0] off, input logic [1:0] sz);
    logic [3:0] be;
    case (sz)
      SZ_B:    be = 4'b1000 >> off;
      SZ_H:    be = off[1] ? 4'b0011 : 4'b1100;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Store data replicated so every lane carries the right-aligned value.
  function automatic logic [31:0] store_data(input logic [31:0] sdata, input logic [1:0] sz);
    logic [31:0] d;
    case (sz)
      SZ_B:    d = {4{sdata[7:0]}};
      SZ_H:    d = {2{sdata[15:0]}};
      default: d = sdata;
    endcase
    return d;
  endfunction

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [3:0]         ctx_op_q, cur_op;
  logic [ADDR_W-1:0]  ctx_addr_q, cur_addr;
  logic [31:0]        ctx_sdata_q, cur_sdata, ctx_wdata_q, cur_wdata;
  logic [31:0]        ctx_hi_q, cur_hi, ctx_lo_q, cur_lo;
  logic [RADDR_W-1:0] ctx_wd_q, cur_wd;
  logic               ctx_wreg_q, cur_wreg, ctx_whilo_q, cur_whilo;
  logic               is_load, is_store, is_signed, misaligned, is_mem;
  logic [1:0]         sz;
  logic               issue, timeout_hit, req_s, stall_s, ack_hit, pass_s;
  logic               wb_valid_q, wb_wreg_q, wb_whilo_q, adel_q, ades_q, berr_q;
  logic [RADDR_W-1:0] wb_wd_q;
  logic [31:0]        wb_wdata_q, wb_hi_q, wb_lo_q;

  // Working context: live EX inputs in IDLE, the latched copy while waiting.
  always_comb begin
    if (state_q == S_WAIT) begin
      cur_op = ctx_op_q;       cur_addr = ctx_addr_q; cur_sdata = ctx_sdata_q;
      cur_wd = ctx_wd_q;       cur_wreg = ctx_wreg_q; cur_wdata = ctx_wdata_q;
      cur_hi = ctx_hi_q;       cur_lo = ctx_lo_q;     cur_whilo = ctx_whilo_q;
    end else begin
      cur_op = mem_op_i;       cur_addr = mem_addr_i; cur_sdata = mem_sdata_i;
      cur_wd = wd_i;           cur_wreg = wreg_i;     cur_wdata = wdata_i;
      cur_hi = hi_i;           cur_lo = lo_i;         cur_whilo = whilo_i;
    end
  end

  // Memory-op decode; opcodes 9-15 behave as NONE.
  always_comb begin
    is_load = 1'b0; is_store = 1'b0; is_signed = 1'b0; sz = SZ_W;
    case (cur_op)
      OP_LB:   begin is_load = 1'b1;  is_signed = 1'b1; sz = SZ_B; end
      OP_LBU:  begin is_load = 1'b1;  sz = SZ_B; end
      OP_LH:   begin is_load = 1'b1;  is_signed = 1'b1; sz = SZ_H; end
      OP_LHU:  begin is_load = 1'b1;  sz = SZ_H; end
      OP_LW:   begin is_load = 1'b1;  sz = SZ_W; end
      OP_SB:   begin is_store = 1'b1; sz = SZ_B; end
      OP_SH:   begin is_store = 1'b1; sz = SZ_H; end
      OP_SW:   begin is_store = 1'b1; sz = SZ_W; end
      default: begin is_load = 1'b0;  is_store = 1'b0; end
    endcase
  end

  assign is_mem      = is_load | is_store;
  assign misaligned  = ((sz == SZ_H) && cur_addr[0]) || ((sz == SZ_W) && (cur_addr[1:0] != 2'b00));
  assign issue       = (state_q == S_IDLE) && ex_valid_i && is_mem && !misaligned;
  assign timeout_hit = (TIMEOUT != 0) && (state_q == S_WAIT) && (cnt_q == TO_CNT);
  // An ack only counts while a request is actually on the bus.
  assign ack_hit     = req_s && dm.dm_ack;
  assign pass_s      = (state_q == S_IDLE) && ex_valid_i && !is_mem;

  // FSM state register and WAIT-cycle counter (cleared whenever not waiting).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= (state_q == S_WAIT) ? cnt_q + CNT_W'(1) : '0;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = (issue && !dm.dm_ack) ? S_WAIT : S_IDLE;
      S_WAIT:  state_d = (ack_hit || timeout_hit) ? S_IDLE : S_WAIT;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs; stall drops in the completing cycle so EX advances once.
  always_comb begin
    req_s = 1'b0; stall_s = 1'b0;
    if (rst) begin
      req_s = 1'b0; stall_s = 1'b0;
    end else begin
      case (state_q)
        S_IDLE:  begin req_s = issue;        stall_s = issue && !dm.dm_ack; end
        S_WAIT:  begin req_s = !timeout_hit; stall_s = !timeout_hit && !dm.dm_ack; end
        default: begin req_s = 1'b0;         stall_s = 1'b0; end
      endcase
    end
  end

  assign dm.dm_req    = req_s;
  assign dm.dm_we     = is_store;
  assign dm.dm_be     = is_store ? store_be(cur_addr[1:0], sz) : 4'b1111;
  assign dm.dm_addr   = {cur_addr[ADDR_W-1:2], 2'b00};
  assign dm.dm_wdata  = store_data(cur_sdata, sz);
  assign stall_req_o  = stall_s;

  // Access context captured every IDLE cycle, frozen while waiting.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctx_op_q <= 4'd0;  ctx_addr_q <= '0;  ctx_sdata_q <= 32'd0; ctx_wd_q <= '0;
      ctx_wreg_q <= 1'b0; ctx_wdata_q <= 32'd0; ctx_hi_q <= 32'd0; ctx_lo_q <= 32'd0;
      ctx_whilo_q <= 1'b0;
    end else if (state_q == S_IDLE) begin
      ctx_op_q <= mem_op_i; ctx_addr_q <= mem_addr_i; ctx_sdata_q <= mem_sdata_i; ctx_wd_q <= wd_i;
      ctx_wreg_q <= wreg_i; ctx_wdata_q <= wdata_i; ctx_hi_q <= hi_i; ctx_lo_q <= lo_i;
      ctx_whilo_q <= whilo_i;
    end else begin
      ctx_op_q <= ctx_op_q;
    end
  end

  // MEM/WB register: completion, faults and bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid_q <= 1'b0; wb_wd_q <= '0; wb_wreg_q <= 1'b0; wb_wdata_q <= 32'd0;
      wb_hi_q <= 32'd0; wb_lo_q <= 32'd0; wb_whilo_q <= 1'b0;
      adel_q <= 1'b0; ades_q <= 1'b0; berr_q <= 1'b0;
    end else begin
      adel_q <= 1'b0; ades_q <= 1'b0; berr_q <= 1'b0;
      if (ack_hit || pass_s) begin
        wb_valid_q <= 1'b1; wb_wd_q <= cur_wd; wb_wreg_q <= cur_wreg;
        wb_wdata_q <= is_load ? load_extract(dm.dm_rdata, cur_addr[1:0], sz, is_signed) : cur_wdata;
        wb_hi_q <= cur_hi; wb_lo_q <= cur_lo; wb_whilo_q <= cur_whilo;
      end else if (timeout_hit) begin
        wb_valid_q <= 1'b1; wb_wreg_q <= 1'b0; wb_whilo_q <= 1'b0; berr_q <= 1'b1;
      end else if ((state_q == S_IDLE) && ex_valid_i && misaligned && is_mem) begin
        wb_valid_q <= 1'b1; wb_wreg_q <= 1'b0; wb_whilo_q <= 1'b0;
        adel_q <= is_load; ades_q <= is_store;
      end else begin
        wb_valid_q <= 1'b0; wb_wreg_q <= 1'b0; wb_whilo_q <= 1'b0;
      end
    end
  end

  assign wb_valid_o = wb_valid_q;
  assign wd_o       = wb_wd_q;
  assign wreg_o     = wb_wreg_q;
  assign wdata_o    = wb_wdata_q;
  assign hi_o       = wb_hi_q;
  assign lo_o       = wb_lo_q;
  assign whilo_o    = wb_whilo_q;
  assign adel_o     = adel_q;
  assign ades_o     = ades_q;
  assign berr_o     = berr_q;
endmodule
